// File: rtl/register32_if.sv
// Data-side bundle of the parallel-load register: capture word, load enable, stored value.
// Latency: none of its own; plain wires between the driver and the register.
// Backpressure: none; load is a level enable with no ready or credit return.
interface register32_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic             load;
    logic [WIDTH-1:0] out;

    // Driver side: presents the word and the enable, observes the stored value.
    modport master (
        output a,
        output load,
        input  out
    );

    // Register side: samples word and enable, drives the stored value.
    modport slave (
        input  a,
        input  load,
        output out
    );
endinterface

// File: rtl/register32.sv
// Parallel-load storage register with async active-high reset to RESET_VALUE.
// Latency: one clk from a to out when load is high at the rising edge; reset is immediate.
// Backpressure: none; the word is always accepted when load is sampled high, held otherwise.
module register32 #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic        clk,
    input logic        res,
    register32_if.slave bus
);

    logic [WIDTH-1:0] q;

    // One flop per bit, each with its own hold/load mux and its own reset value bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic q_bit;

        // Reset wins over load; otherwise capture a[i] on load, else recirculate.
        always_ff @(posedge clk or posedge res) begin
            if (res) begin
                q_bit <= RESET_VALUE[i];
            end else begin
                q_bit <= bus.load ? bus.a[i] : q_bit;
            end
        end

        assign q[i] = q_bit;
    end

    // out comes straight from the flops, no output logic.
    assign bus.out = q;

endmodule

// File: tb/tb_register32.sv
module tb_register32;

    logic clk;
    logic res;
    logic res8;

    int checks;
    int errors;

    register32_if #(.WIDTH(32)) bus ();
    register32_if #(.WIDTH(8))  bus8 ();

    register32 #(.WIDTH(32), .RESET_VALUE(32'h0)) dut (
        .clk (clk),
        .res (res),
        .bus (bus.slave)
    );

    register32 #(.WIDTH(8), .RESET_VALUE(8'h3C)) dut8 (
        .clk (clk),
        .res (res8),
        .bus (bus8.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] seq [4];
    logic [31:0] prev;

    initial begin
        checks = 0;
        errors = 0;
        seq[0] = 32'h1;
        seq[1] = 32'h2;
        seq[2] = 32'h3;
        seq[3] = 32'hFFFF_FFFF;

        // Reset at t=0 with a=3, load low; release at t=10.
        res       = 1'b1;
        res8      = 1'b1;
        bus.a     = 32'd3;
        bus.load  = 1'b0;
        bus8.a    = 8'h00;
        bus8.load = 1'b0;
        #2;
        check_val("reset_out", bus.out, 32'h0);
        check_val("reset8_out", {24'h0, bus8.out}, 32'h3C);
        #8;
        res = 1'b0;
        @(negedge clk);
        check_val("post_release_1", bus.out, 32'h0);
        @(negedge clk);
        check_val("post_release_2", bus.out, 32'h0);

        // Single load then hold with a different a.
        bus.a    = 32'hDEAD_BEEF;
        bus.load = 1'b1;
        @(negedge clk);
        check_val("load_deadbeef", bus.out, 32'hDEAD_BEEF);
        bus.load = 1'b0;
        bus.a    = 32'h1234_5678;
        @(negedge clk);
        check_val("hold_1", bus.out, 32'hDEAD_BEEF);
        @(negedge clk);
        check_val("hold_2", bus.out, 32'hDEAD_BEEF);

        // Glitch on load between edges must not capture.
        #1 bus.load = 1'b1;
        #1 bus.load = 1'b0;
        #1;
        check_val("glitch_no_effect", bus.out, 32'hDEAD_BEEF);
        @(negedge clk);
        check_val("glitch_hold_edge", bus.out, 32'hDEAD_BEEF);

        // Follow a with one cycle of lag.
        prev     = 32'hDEAD_BEEF;
        bus.load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.a = seq[i];
            #1;
            check_val("lag_before_edge", bus.out, prev);
            @(negedge clk);
            check_val("follow_after_edge", bus.out, seq[i]);
            prev = seq[i];
        end

        // Load A5A5A5A5, then short async reset pulse between edges.
        bus.a = 32'hA5A5_A5A5;
        @(negedge clk);
        check_val("load_a5", bus.out, 32'hA5A5_A5A5);
        bus.load = 1'b0;
        #1 res = 1'b1;
        #1;
        check_val("async_reset_immediate", bus.out, 32'h0);
        #1 res = 1'b0;
        @(negedge clk);
        check_val("after_pulse_no_load", bus.out, 32'h0);
        bus.a    = 32'h0000_0005;
        bus.load = 1'b1;
        @(negedge clk);
        check_val("after_pulse_load", bus.out, 32'h5);

        // Reset and load together: reset dominates over several edges.
        res   = 1'b1;
        bus.a = 32'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("reset_dominates", bus.out, 32'h0);
        end
        res = 1'b0;
        #1;
        check_val("release_before_edge", bus.out, 32'h0);
        @(negedge clk);
        check_val("release_then_load", bus.out, 32'h7);

        // Narrow instance: reset value 3C, then load FF.
        @(negedge clk);
        check_val("w8_reset_held", {24'h0, bus8.out}, 32'h3C);
        res8 = 1'b0;
        @(negedge clk);
        check_val("w8_after_release", {24'h0, bus8.out}, 32'h3C);
        bus8.a    = 8'hFF;
        bus8.load = 1'b1;
        @(negedge clk);
        check_val("w8_load_ff", {24'h0, bus8.out}, 32'hFF);
        bus8.load = 1'b0;
        bus8.a    = 8'h11;
        @(negedge clk);
        check_val("w8_hold_ff", {24'h0, bus8.out}, 32'hFF);
        res8 = 1'b1;
        #1;
        check_val("w8_async_reset", {24'h0, bus8.out}, 32'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
